// File: rtl/red_pitaya_iq_boxcar_decimator_pkg.sv
// Shared IQ datapath defaults and helpers for the boxcar decimator.
// The demodulator imports the same widths so both ends agree.
package red_pitaya_iq_boxcar_decimator_pkg;

  localparam int IQ_INBITS    = 18;
  localparam int IQ_LOG2_MAXN = 16;
  localparam int LOG2N_W      = 5;
  localparam int NUM_LANES    = 2;

  function automatic logic [LOG2N_W-1:0] clamp_log2n(input logic [LOG2N_W-1:0] v,
                                                    input int maxn);
    return (int'(v) > maxn) ? LOG2N_W'(maxn) : v;
  endfunction

endpackage

// File: rtl/red_pitaya_iq_boxcar_acc.sv
// One channel of the integrate-and-dump: accumulator, window shift and output register.
module red_pitaya_iq_boxcar_acc
  import red_pitaya_iq_boxcar_decimator_pkg::*;
#(
  parameter int INBITS  = IQ_INBITS,
  parameter int OUTBITS = IQ_INBITS,
  parameter int ACCBITS = IQ_INBITS + IQ_LOG2_MAXN
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clear,
  input  logic                      dump,
  input  logic [LOG2N_W-1:0]        shift,
  input  logic signed [INBITS-1:0]  signal_i,
  output logic signed [OUTBITS-1:0] signal_o
);

  logic signed [ACCBITS-1:0] acc_q, acc_d, acc_base, sum;
  logic signed [INBITS-1:0]  avg;
  logic signed [OUTBITS-1:0] avg_fmt;
  logic signed [OUTBITS-1:0] out_q, out_d;

  // The window average always fits in INBITS, so plain truncation after the shift is exact.
  assign avg = INBITS'(sum >>> shift);

  generate
    if (OUTBITS < INBITS) begin : g_trunc
      assign avg_fmt = OUTBITS'(avg >>> (INBITS - OUTBITS));
    end else begin : g_sext
      assign avg_fmt = OUTBITS'(avg);
    end
  endgenerate

  always_comb begin
    acc_base = clear ? '0 : acc_q;
    sum      = acc_base + {{(ACCBITS-INBITS){signal_i[INBITS-1]}}, signal_i};
    acc_d    = sum;
    out_d    = out_q;
    if (dump) begin
      acc_d = '0;
      out_d = avg_fmt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign signal_o = out_q;

endmodule

// File: rtl/red_pitaya_iq_boxcar_decimator.sv
// IQ boxcar decimator: averages I and Q over 2^log2n samples, one valid strobe per window.
// Holds the shared window counter and decode; per-channel math lives in red_pitaya_iq_boxcar_acc.
module red_pitaya_iq_boxcar_decimator
  import red_pitaya_iq_boxcar_decimator_pkg::*;
#(
  parameter int INBITS    = IQ_INBITS,
  parameter int OUTBITS   = IQ_INBITS,
  parameter int LOG2_MAXN = IQ_LOG2_MAXN
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [LOG2N_W-1:0]        log2n_i,
  input  logic                      sync_i,
  input  logic signed [INBITS-1:0]  signal1_i,
  input  logic signed [INBITS-1:0]  signal2_i,
  output logic signed [OUTBITS-1:0] signal1_o,
  output logic signed [OUTBITS-1:0] signal2_o,
  output logic                      valid_o
);

  localparam int ACCBITS = INBITS + LOG2_MAXN;

  logic [LOG2_MAXN-1:0] cnt_q, cnt_d, win_mask;
  logic [LOG2N_W-1:0]   log2n_q, log2n_d, log2n_eff, log2n_cur, shift;
  logic                 valid_q, valid_d;
  logic                 win_start, win_final, clear, dump;
  logic [LOG2_MAXN:0]   win_len;

  logic [NUM_LANES-1:0][INBITS-1:0]  lane_in;
  logic [NUM_LANES-1:0][OUTBITS-1:0] lane_out;

  always_comb begin
    log2n_eff = clamp_log2n(log2n_i, LOG2_MAXN);
    win_start = (cnt_q == '0);
    // A new log2n only applies from the first sample of a window.
    log2n_cur = win_start ? log2n_eff : log2n_q;
    win_len   = (LOG2_MAXN+1)'(1) << log2n_cur;
    win_mask  = LOG2_MAXN'(win_len - 1'b1);
    win_final = (cnt_q == win_mask);

    clear   = 1'b0;
    dump    = win_final;
    shift   = log2n_cur;
    log2n_d = log2n_cur;
    cnt_d   = win_final ? '0 : LOG2_MAXN'(cnt_q + 1'b1);

    // Sync restarts the window with this sample as sample 0; at N=1 that is just a dump.
    if (sync_i) begin
      clear   = 1'b1;
      shift   = log2n_eff;
      log2n_d = log2n_eff;
      dump    = (log2n_eff == '0);
      cnt_d   = dump ? '0 : LOG2_MAXN'(1);
    end

    valid_d = dump;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      log2n_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      log2n_q <= log2n_d;
      valid_q <= valid_d;
    end
  end

  assign lane_in[0] = signal1_i;
  assign lane_in[1] = signal2_i;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      red_pitaya_iq_boxcar_acc #(
        .INBITS  (INBITS),
        .OUTBITS (OUTBITS),
        .ACCBITS (ACCBITS)
      ) u_acc (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear    (clear),
        .dump     (dump),
        .shift    (shift),
        .signal_i (lane_in[g]),
        .signal_o (lane_out[g])
      );
    end
  endgenerate

  assign signal1_o = lane_out[0];
  assign signal2_o = lane_out[1];
  assign valid_o   = valid_q;

endmodule
